// File: rtl/sw_pkg.sv
// Shared constants for the switch/button read port.
// Status word layout and read-data width.
package sw_pkg;

  localparam int RDATA_W        = 32;
  localparam int STAT_W         = 2;
  localparam int STAT_READY_BIT = 0;
  localparam int STAT_OVR_BIT   = 1;

  // Build the zero-extended status word
  function automatic logic [RDATA_W-1:0] stat_word(
    input logic ovr,
    input logic rdy
  );
    logic [RDATA_W-1:0] w;
    w = '0;
    w[STAT_READY_BIT] = rdy;
    w[STAT_OVR_BIT]   = ovr;
    return w;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// One-bit synchroniser plus tick-sampled debounce filter.
// A new level is accepted after DB_DEPTH equal samples.
module sw_debounce #(
  parameter int DB_DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  input  logic tick_i,
  output logic lvl_o
);

  logic                s1_q;
  logic                s2_q;
  logic [DB_DEPTH-1:0] hist_q;
  logic [DB_DEPTH-1:0] hist_d;
  logic                lvl_q;
  logic                lvl_d;

  // Shift the synchronised sample in on tick; accept on unanimity
  always_comb begin
    hist_d = hist_q;
    lvl_d  = lvl_q;
    if (tick_i) begin
      hist_d = {hist_q[DB_DEPTH-2:0], s2_q};
      if ((&hist_d) || (~|hist_d)) begin
        lvl_d = s2_q;
      end
    end
  end

  // Plain 2-FF synchroniser, then history and level registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      hist_q <= '0;
      lvl_q  <= 1'b0;
    end else begin
      s1_q   <= raw_i;
      s2_q   <= s1_q;
      hist_q <= hist_d;
      lvl_q  <= lvl_d;
    end
  end

  assign lvl_o = lvl_q;

endmodule

// File: rtl/sw_reader.sv
// CPU-readable switch port with debounced capture button.
// Optional macro SW_IRQ_EN adds a level irq that mirrors READY.
module sw_reader
  import sw_pkg::*;
#(
  parameter int SW_W     = 16,
  parameter int DB_DIV   = 50000,
  parameter int DB_DEPTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SW_W-1:0]    sw,
  input  logic               btn,
  input  logic               is_sw,
  input  logic               is_sw_stat,
  output logic [RDATA_W-1:0] rdata
`ifdef SW_IRQ_EN
  ,
  output logic               irq
`endif
);

  localparam int CW = $clog2(DB_DIV);
  localparam int TW = $clog2(DB_DEPTH + 1);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic               arm_q, arm_d;
  logic               prev_q, prev_d;
  logic [SW_W-1:0]    snap_q, snap_d;
  logic               rdy_q, rdy_d;
  logic               ovr_q, ovr_d;
  logic [RDATA_W-1:0] rdata_q, rdata_d;

  logic               tick;
  logic               btn_db;
  logic [SW_W-1:0]    sw_db;
  logic               cap;

  assign tick = (cnt_q == CW'(DB_DIV - 1));

  for (genvar i = 0; i < SW_W; i++) begin : g_sw
    sw_debounce #(.DB_DEPTH(DB_DEPTH)) u_sw (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (sw[i]),
      .tick_i (tick),
      .lvl_o  (sw_db[i])
    );
  end

  sw_debounce #(.DB_DEPTH(DB_DEPTH)) u_btn (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (btn),
    .tick_i (tick),
    .lvl_o  (btn_db)
  );

  // Capture only after a genuinely debounced low since reset,
  // so a button held through reset needs a release first
  assign cap = btn_db & ~prev_q & arm_q;

  // Prescaler, arming, capture/flag update and read mux
  always_comb begin
    cnt_d   = (tick) ? '0 : cnt_q + CW'(1);
    tcnt_d  = tcnt_q;
    if (tick && (tcnt_q != TW'(DB_DEPTH))) begin
      tcnt_d = tcnt_q + TW'(1);
    end
    arm_d   = arm_q | ((tcnt_q == TW'(DB_DEPTH)) & ~btn_db);
    prev_d  = btn_db;
    snap_d  = snap_q;
    rdy_d   = rdy_q;
    ovr_d   = ovr_q;
    rdata_d = rdata_q;
    if (is_sw) begin
      rdata_d             = '0;
      rdata_d[SW_W-1:0]   = snap_q;
      rdy_d               = 1'b0;
      ovr_d               = 1'b0;
    end else if (is_sw_stat) begin
      rdata_d = stat_word(ovr_q, rdy_q);
    end
    if (cap) begin
      snap_d = sw_db;
      rdy_d  = 1'b1;
      if (rdy_q && !is_sw) begin
        ovr_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      tcnt_q  <= '0;
      arm_q   <= 1'b0;
      prev_q  <= 1'b0;
      snap_q  <= '0;
      rdy_q   <= 1'b0;
      ovr_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      arm_q   <= arm_d;
      prev_q  <= prev_d;
      snap_q  <= snap_d;
      rdy_q   <= rdy_d;
      ovr_q   <= ovr_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

`ifdef SW_IRQ_EN
  assign irq = rdy_q;
`endif

endmodule

// File: tb/tb_sw_reader.sv
// Directed bench for sw_reader (SW_W=16, DB_DIV=4, DB_DEPTH=3).
// Define SW_IRQ_EN to also exercise the irq output.
module tb_sw_reader;

  logic        clk;
  logic        rst;
  logic [15:0] sw;
  logic        btn;
  logic        is_sw;
  logic        is_sw_stat;
  logic [31:0] rdata;
`ifdef SW_IRQ_EN
  logic        irq;
`endif

  int passed;
  int total;
  int ph;

  sw_reader #(
    .SW_W     (16),
    .DB_DIV   (4),
    .DB_DEPTH (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .btn        (btn),
    .is_sw      (is_sw),
    .is_sw_stat (is_sw_stat),
    .rdata      (rdata)
`ifdef SW_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Prescaler phase since reset, used to line up timed stimulus
  always @(posedge clk) begin
    if (rst) ph <= 0;
    else     ph <= (ph == 3) ? 0 : ph + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic rd_stat(input string tag, input logic [31:0] exp);
    is_sw_stat = 1'b1;
    @(negedge clk);
    is_sw_stat = 1'b0;
    chk(tag, rdata, exp);
  endtask

  task automatic rd_data(input string tag, input logic [31:0] exp);
    is_sw = 1'b1;
    @(negedge clk);
    is_sw = 1'b0;
    chk(tag, rdata, exp);
  endtask

  task automatic press(input logic [15:0] v);
    sw = v;
    cyc(30);
    btn = 1'b1;
    cyc(40);
    btn = 1'b0;
    cyc(30);
  endtask

  task automatic align0;
    for (int i = 0; i < 8 && ph != 0; i++) @(negedge clk);
  endtask

  initial begin
    passed     = 0;
    total      = 0;
    rst        = 1'b1;
    sw         = '0;
    btn        = 1'b0;
    is_sw      = 1'b0;
    is_sw_stat = 1'b0;
    cyc(2);
    rst = 1'b0;

    // 1 reset state
    chk("rst_rdata", rdata, 32'h0);
    rd_stat("rst_stat", 32'h0);
    rd_data("rst_data", 32'h0);
`ifdef SW_IRQ_EN
    chk("rst_irq", {31'b0, irq}, 32'h0);
`endif
    cyc(40);

    // 2 basic capture
    press(16'hA5C3);
    rd_stat("cap_stat", 32'h1);
`ifdef SW_IRQ_EN
    chk("cap_irq", {31'b0, irq}, 32'h1);
`endif
    rd_data("cap_data", 32'h0000A5C3);
    rd_stat("cap_stat_clr", 32'h0);
`ifdef SW_IRQ_EN
    chk("cap_irq_clr", {31'b0, irq}, 32'h0);
`endif
    cyc(3);
    chk("hold_rdata", rdata, 32'h0);

    // 3 bouncing button, then switch glitch before a real press
    align0();
    for (int i = 0; i < 10; i++) begin
      btn = (i % 2 == 0);
      @(negedge clk);
    end
    btn = 1'b0;
    cyc(30);
    rd_stat("bounce_stat", 32'h0);
    sw = 16'h0F0F;
    cyc(30);
    sw = 16'hFFFF;
    cyc(3);
    sw = 16'h0F0F;
    btn = 1'b1;
    cyc(40);
    btn = 1'b0;
    cyc(30);
    rd_data("glitch_data", 32'h00000F0F);

    // 4 overrun
    press(16'h0001);
    press(16'h0002);
    rd_stat("ovr_stat", 32'h3);
    rd_data("ovr_data", 32'h2);
    rd_stat("ovr_stat_clr", 32'h0);

    // 5 data read in the capture-edge cycle
    press(16'h1111);
    sw = 16'h2222;
    cyc(30);
    align0();
    btn = 1'b1;
    cyc(12);
    is_sw = 1'b1;
    @(negedge clk);
    is_sw = 1'b0;
    chk("col_data_old", rdata, 32'h1111);
    cyc(30);
    btn = 1'b0;
    cyc(30);
    rd_stat("col_stat", 32'h1);
    rd_data("col_data_new", 32'h2222);

    // 6 reset while button held
    sw = 16'hBEEF;
    cyc(30);
    btn = 1'b1;
    cyc(8);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(40);
    rd_stat("mid_stat", 32'h0);
`ifdef SW_IRQ_EN
    chk("mid_irq", {31'b0, irq}, 32'h0);
`endif
    btn = 1'b0;
    cyc(30);
    rd_stat("rel_stat", 32'h0);
    btn = 1'b1;
    cyc(40);
    btn = 1'b0;
    cyc(30);
    rd_stat("repress_stat", 32'h1);
`ifdef SW_IRQ_EN
    chk("repress_irq", {31'b0, irq}, 32'h1);
`endif
    rd_data("repress_data", 32'h0000BEEF);
`ifdef SW_IRQ_EN
    chk("repress_irq_clr", {31'b0, irq}, 32'h0);
`endif
    rd_stat("end_stat", 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
